// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation / decryption stage.
// Reads a length-prefixed ciphertext from CT memory, walks the already keyed S table and
// writes the length-prefixed plaintext to PT memory. All memories are synchronous-read
// (address in cycle n, data in cycle n+1). Every memory-facing output is a register that is
// loaded while leaving a state, so it is presented to the memory during the following state.
module arc4_prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    StIdle,
    StRdLen,
    StLen,
    StRdSi,
    StWtSi,
    StRdSj,
    StWtSj,
    StWrSi,
    StWrSj,
    StRdPad,
    StWtPad,
    StWrPt
  } state_e;

  state_e     state_q;
  logic [7:0] i_q;
  logic [7:0] j_q;
  logic [7:0] k_q;
  logic [7:0] len_q;
  logic [7:0] si_q;
  logic [7:0] sj_q;
  logic [7:0] ctb_q;

  // Idle is the only state that can accept a new message.
  assign rdy = (state_q == StIdle);

  // Sequencer: nine states per byte, two extra for the length prefix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= 8'd0;
      len_q     <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      ctb_q     <= 8'd0;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      ct_addr   <= 8'd0;
      pt_addr   <= 8'd0;
      pt_wrdata <= 8'd0;
      pt_wren   <= 1'b0;
    end else begin
      // Write strobes are single-cycle pulses unless a state below re-arms them.
      s_wren  <= 1'b0;
      pt_wren <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd1;
            ct_addr <= 8'd0;
            state_q <= StRdLen;
          end
        end
        StRdLen: state_q <= StLen;
        StLen: begin
          len_q     <= ct_rddata;
          pt_addr   <= 8'd0;
          pt_wrdata <= ct_rddata;
          pt_wren   <= 1'b1;
          state_q   <= (ct_rddata == 8'd0) ? StIdle : StRdSi;
        end
        StRdSi: begin
          i_q     <= i_q + 8'd1;
          s_addr  <= i_q + 8'd1;
          ct_addr <= k_q;
          state_q <= StWtSi;
        end
        StWtSi: state_q <= StRdSj;
        StRdSj: begin
          si_q    <= s_rddata;
          ctb_q   <= ct_rddata;
          j_q     <= j_q + s_rddata;
          s_addr  <= j_q + s_rddata;
          state_q <= StWtSj;
        end
        StWtSj: state_q <= StWrSi;
        StWrSi: begin
          sj_q     <= s_rddata;
          s_addr   <= i_q;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state_q  <= StWrSj;
        end
        StWrSj: begin
          s_addr   <= j_q;
          s_wrdata <= si_q;
          s_wren   <= 1'b1;
          state_q  <= StRdPad;
        end
        StRdPad: begin
          // Natural 8-bit wrap of the pad index.
          s_addr  <= si_q + sj_q;
          state_q <= StWtPad;
        end
        StWtPad: state_q <= StWrPt;
        StWrPt: begin
          pt_addr   <= k_q;
          pt_wrdata <= s_rddata ^ ctb_q;
          pt_wren   <= 1'b1;
          // Compare before incrementing so L=255 finishes without k wrapping.
          if (k_q == len_q) begin
            state_q <= StIdle;
          end else begin
            k_q     <= k_q + 8'd1;
            state_q <= StRdSi;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_prga.sv
// Scoreboard bench for arc4_prga: expected S and PT writes are queued when a run is issued
// and a negedge monitor pops and compares them whenever the DUT strobes a write enable.
module tb_arc4_prga;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];

  logic       ld_s;
  logic       ld_ct;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  logic [7:0]  model_s [256];
  logic [7:0]  ct_img  [256];
  logic [15:0] s_exp_q  [$];
  logic [15:0] pt_exp_q [$];
  logic [15:0] s_e;
  logic [15:0] pt_e;

  int checks;
  int errors;
  int n;

  arc4_prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories with a bench-side load port.
  always @(posedge clk) begin
    if (ld_s) s_mem[ld_addr] <= ld_data;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ld_ct) ct_mem[ld_addr] <= ld_data;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pt_wren) begin
        if (pt_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pt_unexpected: got pt[%02h]=%02h, want no write", pt_addr, pt_wrdata);
        end else begin
          pt_e = pt_exp_q.pop_front();
          check("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, pt_e});
        end
      end
      if (s_wren) begin
        if (s_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_unexpected: got s[%02h]=%02h, want no write", s_addr, s_wrdata);
        end else begin
          s_e = s_exp_q.pop_front();
          check("s_write", {16'd0, s_addr, s_wrdata}, {16'd0, s_e});
        end
      end
    end
  end

  // Reference ARC4 keystream/decrypt, applying at most max_bytes bytes.
  task automatic model_run(input int max_bytes);
    logic [7:0] i, j, l, t, pad;
    l = ct_img[0];
    pt_exp_q.push_back({8'd0, l});
    i = 8'd0;
    j = 8'd0;
    for (int k = 1; k <= int'(l) && k <= max_bytes; k++) begin
      i = i + 8'd1;
      j = j + model_s[i];
      s_exp_q.push_back({i, model_s[j]});
      s_exp_q.push_back({j, model_s[i]});
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
      pad = model_s[model_s[i] + model_s[j]];
      pt_exp_q.push_back({8'(k), ct_img[k] ^ pad});
    end
  endtask

  task automatic model_init_ksa();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h00;
    key[1] = 8'h03;
    key[2] = 8'h18;
    for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + model_s[a] + key[a % 3];
      t = model_s[a];
      model_s[a] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic load_s();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_s    = 1'b1;
      ld_addr = 8'(a);
      ld_data = model_s[a];
    end
    @(negedge clk);
    ld_s = 1'b0;
  endtask

  task automatic load_ct();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_ct   = 1'b1;
      ld_addr = 8'(a);
      ld_data = ct_img[a];
    end
    @(negedge clk);
    ld_ct = 1'b0;
  endtask

  task automatic random_ct(input logic [7:0] len);
    ct_img[0] = len;
    for (int a = 1; a < 256; a++) ct_img[a] = 8'($urandom_range(0, 255));
  endtask

  // Start a run and count rdy-low cycles; optionally pulse en once mid-run.
  task automatic start_run(input int pulse_at, output int cnt);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    cnt = 0;
    while (!rdy && cnt < 4000) begin
      en = (cnt == pulse_at);
      cnt++;
      @(posedge clk);
      #1;
    end
    en = 1'b0;
  endtask

  task automatic end_run(input string name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_pt_left"}, pt_exp_q.size(), 0);
    check({name, "_s_left"}, s_exp_q.size(), 0);
  endtask

  task automatic check_s_table(input string name);
    int bad;
    bad = -1;
    for (int a = 0; a < 256; a++) begin
      if (s_mem[a] !== model_s[a] && bad < 0) bad = a;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: s[%0d] is %02h, want %02h", name, bad, s_mem[bad], model_s[bad]);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    ld_s    = 1'b0;
    ld_ct   = 1'b0;
    ld_addr = 8'd0;
    ld_data = 8'd0;

    // Reset state.
    #3;
    check("rst_rdy", rdy, 1);
    check("rst_s_wren", s_wren, 0);
    check("rst_pt_wren", pt_wren, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_ct_addr", ct_addr, 0);
    check("rst_pt_addr", pt_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity S, two-byte message with hand-computed results.
    for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    load_s();
    random_ct(8'd2);
    ct_img[1] = 8'hAA;
    ct_img[2] = 8'hBB;
    load_ct();
    s_exp_q.push_back(16'h0101);
    s_exp_q.push_back(16'h0101);
    s_exp_q.push_back(16'h0203);
    s_exp_q.push_back(16'h0302);
    pt_exp_q.push_back(16'h0002);
    pt_exp_q.push_back(16'h01A8);
    pt_exp_q.push_back(16'h02BE);
    start_run(-1, n);
    check("ident_cycles", n, 20);
    end_run("ident");
    check("ident_s2", s_mem[2], 8'h03);
    check("ident_s3", s_mem[3], 8'h02);
    model_s[2] = 8'h03;
    model_s[3] = 8'h02;
    check_s_table("ident_table");

    // Zero-length message: only pt[0] written, two busy cycles.
    ct_img[0] = 8'd0;
    load_ct();
    model_run(256);
    start_run(-1, n);
    check("zero_cycles", n, 2);
    end_run("zero");
    check_s_table("zero_table");

    // Reset during RD_SJ of byte 3, then restart on the partially permuted S.
    random_ct(8'd5);
    load_ct();
    model_run(2);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", rdy, 1);
    check("midrst_s_wren", s_wren, 0);
    check("midrst_pt_wren", pt_wren, 0);
    @(negedge clk);
    rst_n = 1'b1;
    end_run("midrst");
    check_s_table("midrst_table");
    model_run(256);
    start_run(-1, n);
    check("restart_cycles", n, 47);
    end_run("restart");
    check_s_table("restart_table");

    // Keyed S, full 255-byte message, stray en pulse mid-run.
    model_init_ksa();
    load_s();
    random_ct(8'd255);
    load_ct();
    model_run(256);
    start_run(100, n);
    check("long_cycles", n, 2297);
    end_run("long");
    check_s_table("long_table");

    // en held high: back-to-back runs with one idle cycle between them.
    random_ct(8'd4);
    load_ct();
    model_run(256);
    model_run(256);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!rdy && n < 4000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("held_first_cycles", n, 38);
    @(posedge clk);
    #1;
    check("held_restart", rdy, 0);
    en = 1'b0;
    n  = 0;
    while (!rdy && n < 4000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("held_second_cycles", n, 38);
    end_run("held");
    check_s_table("held_table");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- Pseudo-random generation / decryption stage of the ARC4 pipeline.
- Consumes the S table after init and KSA have filled it, and reads a length-prefixed ciphertext from CT memory.
- Writes the length-prefixed plaintext to PT memory.
- Sits beside ksa under the top-level controller and shares the same en/rdy handshake and synchronous-memory conventions.

Parameters:
- None. Widths are fixed: 8-bit data and 8-bit addresses (256-entry S, CT and PT memories).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  high when idle and able to accept en
- s_addr  output  8  S memory address
- s_rddata  input  8  S read data, valid one cycle after s_addr
- s_wrdata  output  8  S write data
- s_wren  output  1  S write enable
- ct_addr  output  8  ciphertext memory address
- ct_rddata  input  8  CT read data, valid one cycle after ct_addr
- pt_addr  output  8  plaintext memory address
- pt_wrdata  output  8  PT write data
- pt_wren  output  1  PT write enable

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 immediately forces state IDLE, rdy=1, s_wren=0, pt_wren=0.
  - All addresses, wrdata and internal registers i, j, k, L, si, sj, ctb clear to 0.
  - Reset mid-run abandons the message. S stays partially permuted; the controller must rerun init and KSA.
- Memories are synchronous-read: address presented in cycle n, data valid in cycle n+1.
- Handshake:
  - en accepted on a rising edge with rdy=1.
  - rdy=0 from the next cycle until the final PT write completes.
  - en while rdy=0 is ignored.
  - en held high continuously restarts a new run the cycle after rdy returns.
- Algorithm, all arithmetic mod 256 (natural 8-bit wrap):
  - L = ct[0]; pt[0] = L.
  - For k = 1..L: i = i+1; j = j+s[i]; swap s[i], s[j]; pt[k] = ct[k] XOR s[s[i]+s[j]].
  - i and j reset to 0 at every start.
- States (outputs decoded from state plus registers; wren only in the stated states):
  - IDLE: rdy=1. On en: i=j=0, k=1, ct_addr=0 → RD_LEN.
  - RD_LEN: wait for ct[0] → LEN.
  - LEN: L=ct_rddata; pt_addr=0, pt_wrdata=L, pt_wren=1. If L==0 → IDLE, else → RD_SI.
  - RD_SI: i=i+1; s_addr=i+1; ct_addr=k → WT_SI.
  - WT_SI → RD_SJ.
  - RD_SJ: si=s_rddata; ctb=ct_rddata; j=j+si; s_addr=j+si → WT_SJ.
  - WT_SJ → WR_SI.
  - WR_SI: sj=s_rddata; s_addr=i, s_wrdata=sj, s_wren=1 → WR_SJ.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1 → RD_PAD.
  - RD_PAD: s_addr=si+sj → WT_PAD.
  - WT_PAD → WR_PT.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata^ctb, pt_wren=1. If k==L → IDLE, else k=k+1 → RD_SI.
- Latency:
  - Exactly 9 cycles per byte.
  - rdy is low for exactly 2+9L cycles.
- Boundary conditions:
  - i==j: both swap writes hit the same address with the same value; S is unchanged.
  - L=255: the k==L compare occurs before increment, so k never wraps.
  - Pad index wraps when si+sj ≥ 256.
  - ct[k] for k > L is never read; PT above L is never written.

Test Plan:
1. rst_n pulsed low during RD_SJ of byte 3 → rdy=1 and both wren=0 asynchronously. A new en then restarts with i=j=0 and rewrites pt[0].
2. ct[0]=0x00, any S → single write pt[0]=0x00, no s_wren pulses, rdy low exactly 2 cycles.
3. Identity S (s[x]=x), ct={0x02,0xAA,0xBB}:
   - pt={0x02,0xA8,0xBE};
   - afterwards s[2]=0x03, s[3]=0x02, all other entries unchanged;
   - rdy low exactly 20 cycles.
4. S from init+KSA with key 24'h000318, random 255-byte ciphertext:
   - every pt[k] matches a software ARC4 model;
   - rdy low exactly 2297 cycles;
   - i and j wrap cleanly.
5. en held high through completion → second run starts the cycle after rdy rises, operates on the already-permuted S with i=j=0, and matches the model. en pulses mid-run cause no effect.
6. Write-port checks:
   - every s_wren cycle occurs only in WR_SI/WR_SJ with the expected addresses;
   - pt_wren asserts exactly L+1 times per run, with ascending pt_addr 0..L.
